vga_pattern_gen: RTL and testbench
==================================

// Module: vga_pattern_gen
// PURPOSE
//  Parametrised VGA raster timing and test-pattern generator. Derives a pixel-clock enable from clk,
//  scans a programmable H/V raster, and drives sync, data-enable, pixel coordinates and RGB pattern data.
//  Sits between the board clock and the VGA DAC pins. Reusable for any mode via parameters.
// PARAMETERS
//  CLK_DIV    2    clk cycles per pixel (1,2,4); pix_ce asserted 1 of every CLK_DIV clk
//  COLOR_W    4    bits per colour channel; rgb = {R,G,B}
//  CNT_W      12   width of h/v counters and x/y outputs
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   horizontal sync width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines)
//  V_BP       33   vertical back porch (lines)
//  HS_POL     0    hsync active level
//  VS_POL     0    vsync active level
//  BAR_SHIFT  6    colour-bar width = 2**BAR_SHIFT pixels
//  CHK_SHIFT  5    checker square = 2**CHK_SHIFT pixels
//  GRID_SHIFT 5    grid pitch = 2**GRID_SHIFT pixels
// PORTS
//  clk          in   1          system clock
//  reset_n      in   1          asynchronous, active-low reset
//  mode         in   2          pattern select: 0 bars, 1 checker, 2 grid, 3 solid
//  solid_color  in   3*COLOR_W  colour for mode 3
//  hsync        out  1          horizontal sync, polarity HS_POL
//  vsync        out  1          vertical sync, polarity VS_POL
//  de           out  1          high during active pixel
//  x            out  CNT_W      active pixel column (valid when de)
//  y            out  CNT_W      active pixel row (valid when de)
//  frame_start  out  1          one-clk pulse with pixel (0,0)
//  rgb          out  3*COLOR_W  pixel data, 0 when de low
// BEHAVIOUR
//  - Reset: div counter, hcnt, vcnt = 0; hsync = ~HS_POL; vsync = ~VS_POL; de, x, y, frame_start, rgb = 0; mode_q = 0.
//  - pix_ce: div counter 0..CLK_DIV-1, pix_ce high when count = CLK_DIV-1 (CLK_DIV = 1 -> always high). No derived clocks.
//  - On pix_ce: hcnt wraps at H_TOTAL-1 -> 0 (H_TOTAL = sum of H_*); vcnt increments on hcnt wrap, wraps at V_TOTAL-1 -> 0.
//  - All outputs registered on pix_ce from current hcnt/vcnt: one pixel-tick latency, all outputs mutually aligned.
//  - hsync active iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on vcnt with V_* (changes on line wrap).
//  - de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE); x = hcnt, y = vcnt when de, else held 0.
//  - frame_start high for exactly one clk: the clk in which registered outputs present (0,0); zero otherwise.
//  - mode_q <= mode only at hcnt = 0, vcnt = 0 (frame boundary). Mid-frame mode changes take effect on next frame.
//  - Patterns (F = all-ones COLOR_W):
//      mode 0: b = x[BAR_SHIFT+2:BAR_SHIFT]; R = b[0]?F:0, G = b[1]?F:0, B = b[2]?F:0.
//      mode 1: white if x[CHK_SHIFT]^y[CHK_SHIFT], else black.
//      mode 2: white if x[GRID_SHIFT-1:0] = 0 or y[GRID_SHIFT-1:0] = 0, else black.
//      mode 3: solid_color.
//  - Reset mid-frame: all state returns to reset values immediately; scan restarts at (0,0) after release.
// CONFIGURATION
//  VGA_BORDER_EN defined: active pixels with x = 0, x = H_ACTIVE-1, y = 0 or y = V_ACTIVE-1 force rgb to all-ones, overriding the pattern.
//  VGA_BORDER_EN undefined: no override; pattern alone drives rgb.
// STRUCTURE
//  - Package vga_pkg: mode encodings (MODE_BARS, MODE_CHECKER, MODE_GRID, MODE_SOLID); default 640x480 timing constants.
//  - Sub-module vga_timing_core: pix_ce divider, h/v counters, sync/de/coords.
//  - Top: mode latch, pattern logic, border option.
// TESTING
//  1. Defaults, reset release -> hsync low 96 ticks (192 clk), period 800 ticks; vsync low 2 lines, period 525 lines.
//  2. One full frame -> de high exactly 307200 ticks; x spans 0..639, y spans 0..479; frame_start once per 420000 ticks.
//  3. mode = 0 -> x = 0..63 rgb = 12'h000, x = 64 rgb = 12'hF00, x = 128 rgb = 12'h0F0, x = 448 rgb = 12'hFFF.
//  4. Switch mode 0 -> 3 (solid_color = 12'h5A3) at y = 200 -> bars until frame end; 12'h5A3 from next frame_start.
//  5. Assert reset_n mid-line at hcnt = 300 -> outputs at reset values same cycle; after release first frame_start at 0 ticks latency + 1.
//  6. VGA_BORDER_EN, mode 3 solid 12'h000 -> rgb = 12'hFFF at x = 0, x = 639, y = 0, y = 479; 12'h000 elsewhere in active.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern generator: pattern mode encodings and
// the default 640x480@60 raster timing.
package vga_pkg;
  localparam logic [1:0] MODE_BARS    = 2'd0;
  localparam logic [1:0] MODE_CHECKER = 2'd1;
  localparam logic [1:0] MODE_GRID    = 2'd2;
  localparam logic [1:0] MODE_SOLID   = 2'd3;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
endpackage

// File: rtl/vga_timing_core.sv
// Raster timing: pixel-clock enable divider, H/V scan counters and registered
// sync / data-enable / coordinate outputs, one pixel tick behind the counters.
module vga_timing_core #(
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 12,
  parameter int H_ACTIVE = vga_pkg::DEF_H_ACTIVE,
  parameter int H_FP     = vga_pkg::DEF_H_FP,
  parameter int H_SYNC   = vga_pkg::DEF_H_SYNC,
  parameter int H_BP     = vga_pkg::DEF_H_BP,
  parameter int V_ACTIVE = vga_pkg::DEF_V_ACTIVE,
  parameter int V_FP     = vga_pkg::DEF_V_FP,
  parameter int V_SYNC   = vga_pkg::DEF_V_SYNC,
  parameter int V_BP     = vga_pkg::DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             pix_ce,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             h_last, v_last, hs_on, vs_on, origin;

  assign pix_ce = (div == DIV_W'(CLK_DIV - 1));
  assign h_last = (hcnt == CNT_W'(H_TOTAL - 1));
  assign v_last = (vcnt == CNT_W'(V_TOTAL - 1));
  assign active = (hcnt < CNT_W'(H_ACTIVE)) && (vcnt < CNT_W'(V_ACTIVE));
  assign hs_on  = (hcnt >= CNT_W'(H_ACTIVE + H_FP)) && (hcnt < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on  = (vcnt >= CNT_W'(V_ACTIVE + V_FP)) && (vcnt < CNT_W'(V_ACTIVE + V_FP + V_SYNC));
  assign origin = (hcnt == '0) && (vcnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      div <= pix_ce ? '0 : div + 1'b1;
      if (pix_ce) begin
        hcnt <= h_last ? '0 : hcnt + 1'b1;
        if (h_last) vcnt <= v_last ? '0 : vcnt + 1'b1;
      end
    end
  end

  // frame_start is evaluated every clk so it lasts one clk, not one pixel tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && origin;
      if (pix_ce) begin
        hsync <= hs_on ? HS_POL : ~HS_POL;
        vsync <= vs_on ? VS_POL : ~VS_POL;
        de    <= active;
        x     <= active ? hcnt : '0;
        y     <= active ? vcnt : '0;
      end
    end
  end
endmodule

// File: rtl/vga_pattern_gen.sv
// VGA raster timing plus test-pattern generator (bars, checker, grid, solid).
// Optional feature macro VGA_BORDER_EN: forces a white one-pixel frame border.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int COLOR_W    = 4,
  parameter int CNT_W      = 12,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int BAR_SHIFT  = 6,
  parameter int CHK_SHIFT  = 5,
  parameter int GRID_SHIFT = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_color,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [CNT_W-1:0]     x,
  output logic [CNT_W-1:0]     y,
  output logic                 frame_start,
  output logic [3*COLOR_W-1:0] rgb
);
  logic             pix_ce, active, origin;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic [1:0]       mode_q, mode_eff;
  logic [2:0]       bar;
  logic [3*COLOR_W-1:0] pat;

  vga_timing_core #(
    .CLK_DIV(CLK_DIV), .CNT_W(CNT_W),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .hcnt(hcnt), .vcnt(vcnt),
    .active(active), .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start)
  );

  // The pixel at (0,0) already uses the mode being latched on that tick.
  assign origin   = (hcnt == '0) && (vcnt == '0);
  assign mode_eff = origin ? mode : mode_q;
  assign bar      = hcnt[BAR_SHIFT+2:BAR_SHIFT];

  always_comb begin
    pat = '0;
    case (mode_eff)
      MODE_BARS:    pat = {{COLOR_W{bar[0]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[2]}}};
      MODE_CHECKER: pat = (hcnt[CHK_SHIFT] ^ vcnt[CHK_SHIFT]) ? '1 : '0;
      MODE_GRID:    pat = ((hcnt[GRID_SHIFT-1:0] == '0) || (vcnt[GRID_SHIFT-1:0] == '0)) ? '1 : '0;
      default:      pat = solid_color;
    endcase
`ifdef VGA_BORDER_EN
    if ((hcnt == '0) || (hcnt == CNT_W'(H_ACTIVE - 1)) ||
        (vcnt == '0) || (vcnt == CNT_W'(V_ACTIVE - 1)))
      pat = '1;
`else
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_BARS;
      rgb    <= '0;
    end else if (pix_ce) begin
      if (origin) mode_q <= mode;
      rgb <= active ? pat : '0;
    end
  end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a reduced 16x8 raster (24x12 total).
module tb_vga_pattern_gen;
  localparam int HT = 24;
`ifdef VGA_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] solid_color = 12'h000;
  logic        hsync, vsync, de, frame_start;
  logic [11:0] x, y, rgb;

  int errors = 0;
  int checks = 0;
  int pos = 0;
  int lat;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .CLK_DIV(2), .COLOR_W(4), .CNT_W(12),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .BAR_SHIFT(1), .CHK_SHIFT(1), .GRID_SHIFT(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .solid_color(solid_color),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .rgb(rgb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns clks until frame_start is seen at a negedge; resets the position.
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3000);
    if (!frame_start) begin
      checks++;
      errors++;
      $error("FAIL fs_timeout: observed no frame_start after %0d clks", n);
    end
    pos = 0;
  endtask

  task automatic goto(input int h, input int v);
    int tgt;
    tgt = v * HT + h;
    repeat ((tgt - pos) * 2) @(negedge clk);
    pos = tgt;
  endtask

  initial begin
    int clks, dec, hsl, vsl, fsc, xmax, ymax;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_xy", {x, y}, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_rgb", rgb, 0);
    reset_n = 1'b1;
    wait_fs(lat);
    chk("fs_latency", lat, 2);

    // whole frame 0 statistics
    clks = 0; dec = 0; hsl = 0; vsl = 0; fsc = 0; xmax = 0; ymax = 0;
    do begin
      if (de) begin
        dec++;
        if (int'(x) > xmax) xmax = int'(x);
        if (int'(y) > ymax) ymax = int'(y);
      end
      if (!hsync) hsl++;
      if (!vsync) vsl++;
      if (frame_start) fsc++;
      @(negedge clk);
      clks++;
    end while (!frame_start && clks < 3000);
    pos = 0;
    chk("frame_clks", clks, 576);
    chk("de_clks", dec, 256);
    chk("hsync_low_clks", hsl, 72);
    chk("vsync_low_clks", vsl, 96);
    chk("fs_count", fsc, 1);
    chk("x_max", xmax, 15);
    chk("y_max", ymax, 7);

    // frame 1: bars, sync edges, deferred mode switch
    chk("f1_origin", {de, x, y}, {1'b1, 24'h0});
    chk("f1_rgb00", rgb, BORDER ? 12'hFFF : 12'h000);
    @(negedge clk);
    chk("fs_width", frame_start, 0);
    pos = 0;
    goto(1, 1);  chk("bar_x1", rgb, 12'h000);
    goto(2, 1);  chk("bar_x2", rgb, 12'hF00);
    chk("bar_xy", {x, y}, {12'd2, 12'd1});
    goto(4, 1);  chk("bar_x4", rgb, 12'h0F0);
    goto(14, 1); chk("bar_x14", rgb, 12'hFFF);
    goto(16, 2); chk("blank_h", {de, x, rgb}, 0);
    goto(17, 2); chk("hs_17", hsync, 1);
    goto(18, 2); chk("hs_18", hsync, 0);
    goto(20, 2); chk("hs_20", hsync, 0);
    goto(21, 2); chk("hs_21", hsync, 1);
    goto(3, 3);
    mode = 2'd3; solid_color = 12'h5A3;
    goto(2, 4);  chk("midframe_bars", rgb, 12'hF00);
    goto(0, 8);  chk("vs_8", {vsync, de}, 2'b10);
    goto(0, 9);  chk("vs_9", {vsync, de, y}, 0);
    goto(0, 11); chk("vs_11", vsync, 1);

    // frame 2: solid
    wait_fs(lat);
    goto(5, 2);  chk("solid", rgb, 12'h5A3);
    mode = 2'd1;
    goto(2, 3);  chk("solid_hold", rgb, 12'h5A3);

    // frame 3: checker
    wait_fs(lat);
    goto(2, 1);  chk("chk_2_1", rgb, 12'hFFF);
    goto(4, 1);  chk("chk_4_1", rgb, 12'h000);
    goto(3, 2);  chk("chk_3_2", rgb, 12'h000);
    goto(5, 2);  chk("chk_5_2", rgb, 12'hFFF);
    mode = 2'd2;

    // frame 4: grid
    wait_fs(lat);
    goto(4, 1);  chk("grid_4_1", rgb, 12'hFFF);
    goto(5, 2);  chk("grid_5_2", rgb, 12'h000);
    goto(5, 4);  chk("grid_5_4", rgb, 12'hFFF);
    mode = 2'd3; solid_color = 12'h000;

    // frame 5: black solid, border option, then mid-line reset
    wait_fs(lat);
`ifdef VGA_BORDER_EN
    goto(5, 0);  chk("brd_top", rgb, 12'hFFF);
    goto(0, 3);  chk("brd_left", rgb, 12'hFFF);
`endif
    goto(5, 3);  chk("blk_5_3", rgb, 12'h000);
`ifdef VGA_BORDER_EN
    goto(15, 3); chk("brd_right", rgb, 12'hFFF);
    goto(5, 7);  chk("brd_bottom", rgb, 12'hFFF);
`endif
    solid_color = 12'h0C7;
    goto(10, 7); chk("pre_rst", {de, x, y, rgb}, {1'b1, 12'd10, 12'd7, BORDER ? 12'hFFF : 12'h0C7});
    reset_n = 1'b0;
    #1;
    chk("mid_rst", {hsync, vsync, de, frame_start}, 4'b1100);
    chk("mid_rst_xyrgb", {x, y, rgb}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_fs(lat);
    chk("rst2_latency", lat, 2);
    chk("rst2_origin", {de, x, y}, {1'b1, 24'h0});
    goto(5, 3);  chk("rst2_solid", rgb, 12'h0C7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
